// File: rtl/id_stage_if.sv
// Fetch-side, execute-side and writeback signals of the decode stage, bundled with
// modports for the stage itself (slave) and whatever drives it (master).
interface id_stage_if #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
);
  localparam int RAW = $clog2(REG_COUNT);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;

  logic            wb_we;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [RAW-1:0]  out_rd;
  logic [RAW-1:0]  out_rs1;
  logic [RAW-1:0]  out_rs2;
  logic [6:0]      out_funct7;
  logic [2:0]      out_funct3;
  logic            out_alu_src;
  logic            out_branch;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_mem_to_reg;
  logic            out_reg_write;
  logic [1:0]      out_alu_op;
  logic            out_jal;
  logic            out_jalr;
  logic            out_auipc;
  logic            out_lui;
  logic            out_mac;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, wb_we, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rd, out_rs1, out_rs2, out_funct7, out_funct3, out_alu_src,
           out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write,
           out_alu_op, out_jal, out_jalr, out_auipc, out_lui, out_mac, out_illegal
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, wb_we, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rd, out_rs1, out_rs2, out_funct7, out_funct3, out_alu_src,
           out_branch, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write,
           out_alu_op, out_jal, out_jalr, out_auipc, out_lui, out_mac, out_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I + MAC decode stage: register file with writeback bypass, immediate generation,
// load-use interlock and an ID/EX register with valid/ready handshakes on both sides.
module id_stage #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  id_stage_if.slave   io
);
  localparam int RAW = $clog2(REG_COUNT);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LUI    = 7'b0110111,
    OPC_MAC    = 7'b1111111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            alu_src;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic            jal;
    logic            jalr;
    logic            auipc;
    logic            lui;
    logic            mac;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] rf_q [REG_COUNT];
  idex_t           ex_d, ex_q;
  logic            valid_q;
  logic [6:0]      opcode;
  logic [31:0]     imm32;
  logic            rs1_used, rs2_used;
  logic            load_use;
  logic            in_ready;

  assign opcode = io.in_instr[6:0];

  // NOTE: every output of a combinational block is given a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    ex_d        = '0;
    imm32       = '0;
    rs1_used    = 1'b1;
    rs2_used    = 1'b0;
    ex_d.pc     = io.in_pc;
    ex_d.rd     = io.in_instr[7 +: RAW];
    ex_d.rs1    = io.in_instr[15 +: RAW];
    ex_d.rs2    = io.in_instr[20 +: RAW];
    ex_d.funct3 = io.in_instr[14:12];
    ex_d.funct7 = io.in_instr[31:25];
    case (opcode)
      OPC_OP: begin
        ex_d.reg_write = 1'b1; ex_d.alu_op = 2'b10; rs2_used = 1'b1;
      end
      OPC_OP_IMM: begin
        ex_d.alu_src = 1'b1; ex_d.reg_write = 1'b1; ex_d.alu_op = 2'b10;
        imm32 = {{20{io.in_instr[31]}}, io.in_instr[31:20]};
      end
      OPC_LOAD: begin
        ex_d.alu_src = 1'b1; ex_d.mem_read = 1'b1; ex_d.mem_to_reg = 1'b1;
        ex_d.reg_write = 1'b1;
        imm32 = {{20{io.in_instr[31]}}, io.in_instr[31:20]};
      end
      OPC_STORE: begin
        ex_d.alu_src = 1'b1; ex_d.mem_write = 1'b1; rs2_used = 1'b1;
        imm32 = {{20{io.in_instr[31]}}, io.in_instr[31:25], io.in_instr[11:7]};
      end
      OPC_BRANCH: begin
        ex_d.branch = 1'b1; ex_d.alu_op = 2'b01; rs2_used = 1'b1;
        imm32 = {{19{io.in_instr[31]}}, io.in_instr[31], io.in_instr[7],
                 io.in_instr[30:25], io.in_instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        ex_d.reg_write = 1'b1; ex_d.jal = 1'b1; rs1_used = 1'b0;
        imm32 = {{11{io.in_instr[31]}}, io.in_instr[31], io.in_instr[19:12],
                 io.in_instr[20], io.in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        ex_d.alu_src = 1'b1; ex_d.reg_write = 1'b1; ex_d.jalr = 1'b1;
        imm32 = {{20{io.in_instr[31]}}, io.in_instr[31:20]};
      end
      OPC_AUIPC: begin
        ex_d.alu_src = 1'b1; ex_d.reg_write = 1'b1; ex_d.auipc = 1'b1; rs1_used = 1'b0;
        imm32 = {io.in_instr[31:12], 12'b0};
      end
      OPC_LUI: begin
        ex_d.alu_src = 1'b1; ex_d.reg_write = 1'b1; ex_d.lui = 1'b1; rs1_used = 1'b0;
        imm32 = {io.in_instr[31:12], 12'b0};
      end
      OPC_MAC: begin
        ex_d.reg_write = 1'b1; ex_d.alu_op = 2'b11; ex_d.mac = 1'b1; rs2_used = 1'b1;
      end
      default: begin
        ex_d.illegal = 1'b1; rs1_used = 1'b0;
      end
    endcase
    ex_d.imm = XLEN'($signed(imm32));

    // Writeback in the same cycle is forwarded so the operand is never stale.
    if (ex_d.rs1 == '0)                             ex_d.rs1_data = '0;
    else if (io.wb_we && io.wb_rd == ex_d.rs1)      ex_d.rs1_data = io.wb_data;
    else                                            ex_d.rs1_data = rf_q[ex_d.rs1];
    if (ex_d.rs2 == '0)                             ex_d.rs2_data = '0;
    else if (io.wb_we && io.wb_rd == ex_d.rs2)      ex_d.rs2_data = io.wb_data;
    else                                            ex_d.rs2_data = rf_q[ex_d.rs2];
  end

  assign load_use = valid_q && ex_q.mem_read && (ex_q.rd != '0) && io.in_valid &&
                    ((rs1_used && ex_d.rs1 == ex_q.rd) || (rs2_used && ex_d.rs2 == ex_q.rd));
  assign in_ready = !reset && !load_use && (!valid_q || io.out_ready);

  // NOTE: the register file is cleared on reset like any other state; this keeps it
  // out of plain RAM macros but gives deterministic reads after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (io.wb_we && io.wb_rd != '0) begin
      rf_q[io.wb_rd] <= io.wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (io.flush) begin
      valid_q <= 1'b0;
    end else if (valid_q && !io.out_ready) begin
      valid_q <= valid_q;
    end else if (io.in_valid && in_ready) begin
      valid_q <= 1'b1;
      ex_q    <= ex_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign io.in_ready       = in_ready;
  assign io.out_valid      = valid_q;
  assign io.out_pc         = ex_q.pc;
  assign io.out_rs1_data   = ex_q.rs1_data;
  assign io.out_rs2_data   = ex_q.rs2_data;
  assign io.out_imm        = ex_q.imm;
  assign io.out_rd         = ex_q.rd;
  assign io.out_rs1        = ex_q.rs1;
  assign io.out_rs2        = ex_q.rs2;
  assign io.out_funct7     = ex_q.funct7;
  assign io.out_funct3     = ex_q.funct3;
  assign io.out_alu_src    = ex_q.alu_src;
  assign io.out_branch     = ex_q.branch;
  assign io.out_mem_read   = ex_q.mem_read;
  assign io.out_mem_write  = ex_q.mem_write;
  assign io.out_mem_to_reg = ex_q.mem_to_reg;
  assign io.out_reg_write  = ex_q.reg_write;
  assign io.out_alu_op     = ex_q.alu_op;
  assign io.out_jal        = ex_q.jal;
  assign io.out_jalr       = ex_q.jalr;
  assign io.out_auipc      = ex_q.auipc;
  assign io.out_lui        = ex_q.lui;
  assign io.out_mac        = ex_q.mac;
  assign io.out_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded instructions with hand-computed expectations.
module tb_id_stage;
  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  id_stage_if #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) bus ();

  id_stage #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    // Writes to x5 while in reset must be dropped.
    bus.wb_we   = 1'b1;
    bus.wb_rd   = 5'd5;
    bus.wb_data = 32'hDEAD_BEEF;
    tick;
    check("ready_in_reset", 32'(bus.in_ready), 32'h0);
    tick;
    reset     = 1'b0;
    bus.wb_we = 1'b0;
    #1;
    check("rst_valid",   32'(bus.out_valid), 32'h0);
    check("rst_imm",     bus.out_imm, 32'h0);
    check("rst_pc",      bus.out_pc, 32'h0);
    check("rst_rd",      32'(bus.out_rd), 32'h0);
    check("rst_regw",    32'(bus.out_reg_write), 32'h0);
    check("rst_illegal", 32'(bus.out_illegal), 32'h0);
    check("rst_ready",   32'(bus.in_ready), 32'h1);

    // add x6,x5,x0: x5 must read 0 after reset
    drive(1'b1, 32'h100, 32'h0002_8333);
    tick;
    check("x5_valid",  32'(bus.out_valid), 32'h1);
    check("x5_data",   bus.out_rs1_data, 32'h0);
    check("add_rd",    32'(bus.out_rd), 32'd6);
    check("add_aluop", 32'(bus.out_alu_op), 32'h2);
    check("add_pc",    bus.out_pc, 32'h100);

    // lui x1,0xFFFFF
    drive(1'b1, 32'h104, 32'hFFFF_F0B7);
    tick;
    check("lui_imm",   bus.out_imm, 32'hFFFF_F000);
    check("lui_flag",  32'(bus.out_lui), 32'h1);
    check("lui_src",   32'(bus.out_alu_src), 32'h1);
    check("lui_regw",  32'(bus.out_reg_write), 32'h1);

    // beq x1,x2,-4
    drive(1'b1, 32'h108, 32'hFE20_8EE3);
    tick;
    check("beq_imm",    bus.out_imm, 32'hFFFF_FFFC);
    check("beq_branch", 32'(bus.out_branch), 32'h1);
    check("beq_aluop",  32'(bus.out_alu_op), 32'h1);
    check("beq_regw",   32'(bus.out_reg_write), 32'h0);

    // sw x2,-4(x1)
    drive(1'b1, 32'h10C, 32'hFE20_AE23);
    tick;
    check("sw_imm",  bus.out_imm, 32'hFFFF_FFFC);
    check("sw_memw", 32'(bus.out_mem_write), 32'h1);

    // opcode 1010101
    drive(1'b1, 32'h110, 32'h0000_0055);
    tick;
    check("ill_valid", 32'(bus.out_valid), 32'h1);
    check("ill_flag",  32'(bus.out_illegal), 32'h1);
    check("ill_regw",  32'(bus.out_reg_write), 32'h0);
    check("ill_src",   32'(bus.out_alu_src), 32'h0);
    check("ill_aluop", 32'(bus.out_alu_op), 32'h0);
    check("ill_imm",   bus.out_imm, 32'h0);

    // add x4,x3,x0 with writeback x3=0x1234 in the same cycle
    drive(1'b1, 32'h114, 32'h0001_8233);
    bus.wb_we = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h1234;
    tick;
    check("byp_rs1", bus.out_rs1_data, 32'h1234);
    check("byp_rs2", bus.out_rs2_data, 32'h0);

    // add x4,x0,x3 while writing x0: x0 stays 0, x3 now from the file
    drive(1'b1, 32'h118, 32'h0030_0233);
    bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
    tick;
    bus.wb_we = 1'b0;
    check("x0_rs1",  bus.out_rs1_data, 32'h0);
    check("file_x3", bus.out_rs2_data, 32'h1234);

    // lw x2,0(x1) then add x3,x2,x2 -> one bubble
    drive(1'b1, 32'h11C, 32'h0000_A103);
    tick;
    check("lw_memr",  32'(bus.out_mem_read), 32'h1);
    check("lw_m2r",   32'(bus.out_mem_to_reg), 32'h1);
    check("lw_src",   32'(bus.out_alu_src), 32'h1);
    drive(1'b1, 32'h120, 32'h0021_01B3);
    #1;
    check("lu_stall_ready", 32'(bus.in_ready), 32'h0);
    tick;
    check("lu_bubble", 32'(bus.out_valid), 32'h0);
    check("lu_ready_again", 32'(bus.in_ready), 32'h1);
    tick;
    check("lu_issue_valid", 32'(bus.out_valid), 32'h1);
    check("lu_issue_rd",    32'(bus.out_rd), 32'd3);
    check("lu_issue_pc",    bus.out_pc, 32'h120);

    // lw x2 then lui x2,1 -> no stall
    drive(1'b1, 32'h124, 32'h0000_A103);
    tick;
    drive(1'b1, 32'h128, 32'h0000_1137);
    #1;
    check("lui_nostall_ready", 32'(bus.in_ready), 32'h1);
    tick;
    check("lui2_flag", 32'(bus.out_lui), 32'h1);
    check("lui2_imm",  bus.out_imm, 32'h1000);
    check("lui2_pc",   bus.out_pc, 32'h128);

    // Backpressure: addi x5,x0,7 held for 3 cycles, then addi x6,x0,9 issues
    drive(1'b1, 32'h12C, 32'h0070_0293);
    tick;
    check("bp_first_imm", bus.out_imm, 32'd7);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h130, 32'h0090_0313);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 32'(bus.in_ready), 32'h0);
      tick;
      check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      check("bp_hold_imm",   bus.out_imm, 32'd7);
      check("bp_hold_pc",    bus.out_pc, 32'h12C);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'h1);
    tick;
    check("bp_next_imm", bus.out_imm, 32'd9);
    check("bp_next_rd",  32'(bus.out_rd), 32'd6);

    // Flush while accepting addi x8,x0,5
    drive(1'b1, 32'h134, 32'h0050_0413);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_valid", 32'(bus.out_valid), 32'h0);
    tick;
    check("flush_gone", 32'(bus.out_valid), 32'h0);

    // Flush during a stall empties ID/EX
    drive(1'b1, 32'h138, 32'h0070_0293);
    tick;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    check("flush_stall_valid", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b1;

    // Reset during a stall also wins and clears the fields
    drive(1'b1, 32'h13C, 32'h0070_0293);
    tick;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    check("rst_stall_valid", 32'(bus.out_valid), 32'h0);
    check("rst_stall_imm",   bus.out_imm, 32'h0);
    check("rst_stall_x3",    32'(bus.out_rd), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
